// File: rtl/lane_align_mapper_if.sv
// Bundles the lane_align_mapper data, control and status signals.
// The master side drives the raw lane words and the controls; the slave side is the mapper.
interface lane_align_mapper_if #(
    parameter int N_LANES = 8,
    parameter int RATIO   = 4
);
    localparam int OW = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [N_LANES*RATIO-1:0] DATA_IN;
    logic [N_LANES-1:0]       DISABLE;
    logic                     TRAIN_EN;
    logic [N_LANES*RATIO-1:0] DATA_OUT;
    logic [N_LANES*OW-1:0]    OFFSET;
    logic [N_LANES-1:0]       LOCKED;
    logic                     ALL_LOCKED;
    logic [N_LANES*8-1:0]     ERR_CNT;

    modport master (
        output DATA_IN, DISABLE, TRAIN_EN,
        input  DATA_OUT, OFFSET, LOCKED, ALL_LOCKED, ERR_CNT
    );

    modport slave (
        input  DATA_IN, DISABLE, TRAIN_EN,
        output DATA_OUT, OFFSET, LOCKED, ALL_LOCKED, ERR_CNT
    );
endinterface

// File: rtl/lane_align_mapper.sv
// Per-lane bit-slip word aligner with training-pattern lock FSM.
// Each lane slides a RATIO-bit window over {previous word, current word} until the
// training pattern is seen LOCK_CNT times in a row, then freezes its offset.
// Optional feature: define LANE_ERR_CNT_EN to build the per-lane 8-bit saturating
// mismatch counters on ERR_CNT; otherwise ERR_CNT is tied to zero.
module lane_align_mapper #(
    parameter int               N_LANES       = 8,
    parameter int               RATIO         = 4,
    parameter logic [RATIO-1:0] TRAIN_PATTERN = 4'b0011,
    parameter int               LOCK_CNT      = 16
) (
    input logic                CLK_80,
    input logic                RESET,
    lane_align_mapper_if.slave bus
);
    localparam int OW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CW = $clog2(LOCK_CNT + 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSearch = 3'd1;
    localparam logic [2:0] StBlank  = 3'd2;
    localparam logic [2:0] StVerify = 3'd3;
    localparam logic [2:0] StLocked = 3'd4;

    logic [2:0]       state_q [N_LANES];
    logic [2:0]       state_d [N_LANES];
    logic [OW-1:0]    off_q   [N_LANES];
    logic [OW-1:0]    off_d   [N_LANES];
    logic [CW-1:0]    cnt_q   [N_LANES];
    logic [CW-1:0]    cnt_d   [N_LANES];
    logic [RATIO-1:0] prev_q  [N_LANES];
    logic [RATIO-1:0] lane_a  [N_LANES];

    logic [N_LANES-1:0]       match;
    logic [N_LANES-1:0]       locked_d;
    logic [N_LANES*RATIO-1:0] dout_q;
    logic                     all_q;
    logic                     all_d;
    logic                     train_low_q;
    logic                     train_rise;

    // train_low_q means "TRAIN_EN was low last cycle"; clearing it in reset means a
    // TRAIN_EN held high through reset release is not seen as a rising edge.
    assign train_rise = bus.TRAIN_EN & train_low_q;

    // Aligned word per lane: slice of {previous, current} starting at the lane offset.
    always_comb begin
        for (int k = 0; k < N_LANES; k++) begin
            lane_a[k] = RATIO'({prev_q[k], bus.DATA_IN[k*RATIO +: RATIO]} >> off_q[k]);
            match[k]  = (lane_a[k] == TRAIN_PATTERN);
        end
    end

    // Lane FSM next state: disable beats a training edge, which beats normal progress.
    always_comb begin
        for (int k = 0; k < N_LANES; k++) begin
            state_d[k] = state_q[k];
            off_d[k]   = off_q[k];
            cnt_d[k]   = cnt_q[k];
            if (bus.DISABLE[k]) begin
                state_d[k] = StIdle;
            end else if (train_rise) begin
                state_d[k] = StSearch;
                cnt_d[k]   = '0;
            end else begin
                case (state_q[k])
                    StIdle: ;
                    StSearch, StVerify: begin
                        if (match[k]) begin
                            cnt_d[k] = (state_q[k] == StSearch) ? CW'(1) : cnt_q[k] + CW'(1);
                            if (cnt_d[k] >= CW'(LOCK_CNT)) begin
                                state_d[k] = StLocked;
                            end else begin
                                state_d[k] = StVerify;
                            end
                        end else begin
                            // Slip one bit; the next cycle is blanked while the window settles.
                            off_d[k]   = (off_q[k] == OW'(RATIO - 1)) ? '0 : off_q[k] + OW'(1);
                            state_d[k] = StBlank;
                        end
                    end
                    StBlank:  state_d[k] = StSearch;
                    StLocked: ;
                    default:  state_d[k] = StIdle;
                endcase
            end
            locked_d[k] = (state_d[k] == StLocked);
        end
        all_d = ~(&bus.DISABLE) & (&(locked_d | bus.DISABLE));
    end

    // Lane state, window history, aligned output and lock summary registers.
    always_ff @(posedge CLK_80) begin
        if (RESET) begin
            for (int k = 0; k < N_LANES; k++) begin
                state_q[k] <= StIdle;
                off_q[k]   <= '0;
                cnt_q[k]   <= '0;
                prev_q[k]  <= '0;
            end
            dout_q      <= '0;
            all_q       <= 1'b0;
            train_low_q <= 1'b0;
        end else begin
            for (int k = 0; k < N_LANES; k++) begin
                state_q[k] <= state_d[k];
                off_q[k]   <= off_d[k];
                cnt_q[k]   <= cnt_d[k];
                prev_q[k]  <= bus.DATA_IN[k*RATIO +: RATIO];
                dout_q[k*RATIO +: RATIO] <= bus.DISABLE[k] ? '0 : lane_a[k];
            end
            all_q       <= all_d;
            train_low_q <= ~bus.TRAIN_EN;
        end
    end

    // Pack per-lane status onto the flat output buses.
    always_comb begin
        bus.OFFSET = '0;
        bus.LOCKED = '0;
        for (int k = 0; k < N_LANES; k++) begin
            bus.OFFSET[k*OW +: OW] = off_q[k];
            bus.LOCKED[k]          = (state_q[k] == StLocked);
        end
    end

    assign bus.DATA_OUT   = dout_q;
    assign bus.ALL_LOCKED = all_q;

`ifdef LANE_ERR_CNT_EN
    logic [7:0] err_q [N_LANES];

    // Saturating mismatch count while locked and training is still requested.
    always_ff @(posedge CLK_80) begin
        if (RESET) begin
            for (int k = 0; k < N_LANES; k++) begin
                err_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_LANES; k++) begin
                if (train_rise) begin
                    err_q[k] <= '0;
                end else if ((state_q[k] == StLocked) && bus.TRAIN_EN && !bus.DISABLE[k] &&
                             !match[k] && (err_q[k] != 8'hFF)) begin
                    err_q[k] <= err_q[k] + 8'd1;
                end
            end
        end
    end

    // Pack counters onto ERR_CNT.
    always_comb begin
        bus.ERR_CNT = '0;
        for (int k = 0; k < N_LANES; k++) begin
            bus.ERR_CNT[k*8 +: 8] = err_q[k];
        end
    end
`else
    assign bus.ERR_CNT = '0;
`endif

endmodule

// File: doc/lane_align_mapper.md
LANE_ALIGN_MAPPER -- requirements
Module: lane_align_mapper

Interface
REQ-001 SHALL have parameter N_LANES, default 8: number of deserialized lanes.
REQ-002 SHALL have parameter RATIO, default 4: bits per lane per CLK_80 cycle; legal values 2, 4 or 8.
REQ-003 SHALL have parameter TRAIN_PATTERN, default 4'b0011 (width RATIO): training word; all its rotations must be distinct, otherwise behaviour is undefined.
REQ-004 SHALL have parameter LOCK_CNT, default 16: consecutive matches required for lock.
REQ-005 SHALL have port CLK_80, input, 1: the only clock; all logic is on the rising edge.
REQ-006 SHALL have port RESET, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port DATA_IN, input, N_LANES*RATIO: raw deserializer words; lane k occupies [k*RATIO+RATIO-1:k*RATIO], MSB earliest in time.
REQ-008 SHALL have port DISABLE, input, N_LANES: per-lane disable.
REQ-009 SHALL have port TRAIN_EN, input, 1: training request (level).
REQ-010 SHALL have port DATA_OUT, output, N_LANES*RATIO: aligned words, using the same lane layout as DATA_IN.
REQ-011 SHALL have port OFFSET, output, N_LANES*log2(RATIO): current bit-slip offset per lane.
REQ-012 SHALL have port LOCKED, output, N_LANES: per-lane lock flag.
REQ-013 SHALL have port ALL_LOCKED, output, 1: all enabled lanes are locked.
REQ-014 SHALL have port ERR_CNT, output, N_LANES*8: per-lane mismatch counters.

Function
REQ-015 SHALL register per lane the previous word P and form window W = {P, DATA_IN lane}, 2*RATIO bits wide.
REQ-016 SHALL compute aligned word A = W[RATIO-1+o : o], with lane offset o in 0..RATIO-1; o=0 yields the current word unshifted.
REQ-017 SHALL register DATA_OUT from A: input words of cycles n-1 and n appear at DATA_OUT in cycle n+1, giving one cycle of latency.
REQ-018 SHALL drive DATA_OUT of a disabled lane to all zeros.
REQ-019 SHALL implement a per-lane FSM with states IDLE, SEARCH, BLANK, VERIFY and LOCKED.
REQ-020 IDLE SHALL go to SEARCH on a TRAIN_EN rising edge (relative to the prior cycle) if the lane is enabled.
REQ-021 SEARCH SHALL go to VERIFY with match count 1 if A equals TRAIN_PATTERN; otherwise it SHALL set o to o+1 (wrapping RATIO-1 to 0) and go to BLANK.
REQ-022 BLANK SHALL last exactly one cycle, ignore A, and then return to SEARCH.
REQ-023 VERIFY SHALL increment the match count on each match and go to LOCKED when the count reaches LOCK_CNT.
REQ-024 VERIFY SHALL, on any mismatch, slip o by one and go to BLANK.
REQ-025 LOCKED SHALL hold o frozen and set LOCKED[k]=1; it SHALL be left only on a TRAIN_EN rising edge (to SEARCH, o retained), on disable, or on reset.
REQ-026 A TRAIN_EN rising edge SHALL restart every enabled lane in any state in SEARCH with o retained.
REQ-027 TRAIN_EN low SHALL NOT abort an ongoing search; the lane SHALL continue to LOCKED.
REQ-028 DISABLE[k]=1 SHALL force lane k to IDLE on the next edge, overriding a same-cycle TRAIN_EN edge, with LOCKED[k]=0 and o retained.
REQ-029 ALL_LOCKED SHALL be the AND of LOCKED over enabled lanes, registered; it SHALL be 0 when every lane is disabled.
REQ-030 Match comparison SHALL use A, not DATA_OUT, so that an FSM decision uses the same-cycle window.

Reset
REQ-031 RESET=1 at an edge SHALL set all FSMs to IDLE and clear P, o, match counts, DATA_OUT, LOCKED, ALL_LOCKED and ERR_CNT to 0.
REQ-032 RESET SHALL override all other inputs, including a mid-search state and a simultaneous TRAIN_EN edge.
REQ-033 The TRAIN_EN edge detector SHALL reset to 0, so that TRAIN_EN held high through reset release produces no edge.

Configuration
REQ-034 SHALL compile, with macro LANE_ERR_CNT_EN defined, a per-lane 8-bit counter that increments on each A mismatch while in LOCKED with TRAIN_EN=1, saturates at 255, and clears on a TRAIN_EN rising edge or reset.
REQ-035 SHALL, without LANE_ERR_CNT_EN, keep port ERR_CNT present and drive it constant 0 with no counter logic.

Verification
REQ-036 Defaults, lane 0 fed a stream of 0011 pre-rotated by 2 bits, TRAIN_EN pulsed -> lane 0 reaches LOCKED after the required slips; OFFSET[1:0]=2; DATA_OUT lane 0 = 4'b0011 every cycle.
REQ-037 All 8 lanes fed offsets 0..3 mixed -> ALL_LOCKED=1 only after the slowest lane logs 16 matches; each OFFSET equals its injected skew.
REQ-038 One bit error injected in VERIFY at match 15 -> slip, BLANK, search resumes; no LOCKED pulse.
REQ-039 DISABLE=8'h80 with lane 7 fed random data -> lane 7 stays IDLE; DATA_OUT[31:28]=0; ALL_LOCKED=1 once lanes 0-6 lock.
REQ-040 RESET asserted mid-VERIFY -> next cycle all outputs 0 and OFFSET=0; TRAIN_EN held high through reset release -> no restart.
REQ-041 With LANE_ERR_CNT_EN, 300 mismatches injected while locked with TRAIN_EN=1 -> ERR_CNT lane = 255; without the macro -> ERR_CNT=0.
